// File: rtl/arashi_thread_queue.sv
// Per-thread FIFO bank: THREADS independent DEPTH-entry queues sharing one
// write port and one registered read port, with per-thread status and flush.
module arashi_thread_queue #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH       = 4,
  parameter  int THREADS     = 4,
  parameter  int AFULL_LEVEL = DEPTH - 1,
  localparam int TID_W       = (THREADS > 1) ? $clog2(THREADS) : 1,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  w_ena,
  input  logic [TID_W-1:0]      w_tid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  w_ack,
  output logic                  w_drop,
  input  logic                  r_ena,
  input  logic [TID_W-1:0]      r_tid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  r_valid,
  output logic [TID_W-1:0]      r_tid_out,
  input  logic                  flush,
  input  logic [TID_W-1:0]      flush_tid,
  output logic [THREADS-1:0]    empty,
  output logic [THREADS-1:0]    full,
  output logic [THREADS-1:0]    afull
);

  localparam int IDX_W = CNT_W - 1;

  logic [CNT_W-1:0]      w_ptr [THREADS];
  logic [CNT_W-1:0]      r_ptr [THREADS];
  logic [CNT_W-1:0]      count [THREADS];
  logic [DATA_WIDTH-1:0] mem   [THREADS][DEPTH];

  logic w_tid_ok;
  logic r_tid_ok;
  logic rd_ok;

  // Status is purely a function of the registered pointers; the extra
  // wrap bit makes the modulo difference distinguish full from empty.
  always_comb begin
    for (int t = 0; t < THREADS; t++) begin
      count[t] = w_ptr[t] - r_ptr[t];
      empty[t] = (count[t] == '0);
      full[t]  = (count[t] == CNT_W'(DEPTH));
      afull[t] = (count[t] >= CNT_W'(AFULL_LEVEL));
    end
  end

  // Thread IDs beyond THREADS-1 (non power-of-two banks) are treated as rejects.
  assign w_tid_ok = (int'(w_tid) < THREADS);
  assign r_tid_ok = (int'(r_tid) < THREADS);

  // Flush on the same thread takes priority over both ports.
  assign w_ack = w_ena && w_tid_ok && !full[w_tid] && !(flush && (flush_tid == w_tid));
  assign rd_ok = r_ena && r_tid_ok && !empty[r_tid] && !(flush && (flush_tid == r_tid));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int t = 0; t < THREADS; t++) begin
        w_ptr[t] <= '0;
        r_ptr[t] <= '0;
      end
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        if (flush && (flush_tid == TID_W'(t))) begin
          w_ptr[t] <= '0;
          r_ptr[t] <= '0;
        end else begin
          if (w_ack && (w_tid == TID_W'(t))) w_ptr[t] <= w_ptr[t] + CNT_W'(1);
          if (rd_ok && (r_tid == TID_W'(t))) r_ptr[t] <= r_ptr[t] + CNT_W'(1);
        end
      end
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk) begin
    if (w_ack) mem[w_tid][w_ptr[w_tid][IDX_W-1:0]] <= data_in;
  end

  // Read/drop output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out  <= '0;
      r_tid_out <= '0;
      r_valid   <= 1'b0;
      w_drop    <= 1'b0;
    end else begin
      r_valid <= rd_ok;
      w_drop  <= w_ena && !w_ack;
      if (rd_ok) begin
        data_out  <= mem[r_tid][r_ptr[r_tid][IDX_W-1:0]];
        r_tid_out <= r_tid;
      end
    end
  end

endmodule
